axi4_master_bridge: RTL and testbench
=====================================

Name: axi4_master_bridge

Overview:
- Endpoint bridge between one AXI4 master and one send/recv port pair of the network.
- Converts AW, W and AR beats into flits, one flit per beat.
- Converts flits arriving from the network into B and R beats for the AXI master.
- Flow control uses per-VC non-full vectors in both directions.

Parameters:
- FLIT_WIDTH, 69: flit layout is {valid, tail, dest[1:0], vc[0], data[63:0]}.
- NUM_VCS, 2: VC0 carries writes (AW/W out, B in); VC1 carries reads (AR out, R in).
- SRC_ID, 0: this bridge's network port number, carried in request flits.
- SLAVE_BASE, 2: network port number of slave 0.
- ROUTE_BIT, 31: address bit that selects the slave; dest = SLAVE_BASE + awaddr/araddr[ROUTE_BIT].
- ID_W 4, ADDR_W 32, DATA_W 32, RXQ_DEPTH 4.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset.
- axi  interface  -  axi_interface.slave modport:
  - aw*: id, addr, len, size, burst, valid in; ready out.
  - w*: data, strb, last, valid in; ready out.
  - ar*: same fields as aw*, valid in; ready out.
  - b*: id, resp, valid out; ready in.
  - r*: id, data, resp, last, valid out; ready in.
- put_flit  out  FLIT_WIDTH  flit to network.
- put_flit_valid  out  1  put_flit is valid this cycle.
- get_non_full_vcs  in  NUM_VCS  network input VC non-full bits.
- get_non_full_vcs_ready  out  1  tied 1.
- get_flit  in  FLIT_WIDTH  flit from network; bit FLIT_WIDTH-1 = valid.
- get_flit_ready  out  1  tied 1 (always accept).
- put_non_full_vcs  out  NUM_VCS  bridge receive-queue credit bits.
- put_non_full_vcs_valid  out  1  tied 1.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (CLK, RST_N).
- Reset values:
  - FSM = IDLE; RX queues empty; priority pointer = write.
  - All AXI valid/ready outputs = 0; put_flit_valid = 0.
  - put_non_full_vcs = all 1.
- Data field: tag at data[63:61] (AW=0, W=1, B=2, AR=3, R=4). Remaining fields are packed MSB-down directly below the tag, unused bits 0.
  - AW/AR flit: src[1:0], id, addr, len, size, burst.
  - W flit: data, strb, last.
  - B flit: id, resp.
  - R flit: id, data, resp, last.
- TX FSM states: IDLE, WDATA.
- IDLE arbitration:
  - Candidates: write (awvalid && nonfull[0]) and read (arvalid && nonfull[1]).
  - If both are candidates, the priority pointer decides; the pointer flips after each grant.
- AW grant:
  - awready = 1 combinationally; emits AW flit, tail=0, vc=0.
  - Latches dest; goes to WDATA.
- AR grant:
  - arready = 1; emits AR flit, tail=1, vc=1.
  - Stays in IDLE.
- WDATA:
  - wready = wvalid && nonfull[0].
  - Each accepted beat emits a W flit, vc=0, latched dest; tail = wlast.
  - wlast returns to IDLE.
  - No AR is accepted during WDATA.
- At most one flit per cycle.
- put_flit_valid is asserted only in a cycle where the matching get_non_full_vcs bit is 1. Flit fields are combinational from AXI inputs.
- RX path:
  - Valid incoming flits are pushed into FIFO[vc], each RXQ_DEPTH deep.
  - put_non_full_vcs[v] = 1 while FIFO[v] has ≥2 free entries. The extra entry covers one cycle of credit latency.
  - A push into a full FIFO is a protocol error: the flit is dropped and a simulation error is reported.
- B channel: bvalid = FIFO0 non-empty and head tag == B; pop on bvalid && bready.
- R channel: rvalid = FIFO1 non-empty and head tag == R; pop on rvalid && rready.
- A head flit with any other tag is popped and discarded the next cycle without asserting valid.
- Simultaneous push and pop on the same FIFO is allowed; the count is unchanged.
- B and R are independent and may be valid in the same cycle.
- Reset asserted mid-burst: FSM aborts to IDLE and queues are flushed; no tail flit is emitted for the aborted burst.

Test Plan:
- Write, awaddr=0x0000_0010, awlen=1, id=3, 2 W beats, nonfull=2'b11:
  - 3 flits with dest=2, vc=0, tails 0,0,1; awready in cycle 0, wready in cycles 1–2.
- Read, araddr=0x8000_0000, id=5:
  - single AR flit, dest=3, vc=1, tail=1, src=SRC_ID, arready for 1 cycle.
- awvalid and arvalid both held with nonfull=2'b11:
  - first grant is write; AR is granted only after wlast.
  - two back-to-back AR-vs-AW conflicts alternate grants.
- get_non_full_vcs=2'b10 with a pending write:
  - awready=0 and put_flit_valid=0 until bit0 rises; the AW flit goes out that same cycle.
- Inject 4 R flits on vc1 while rready=0:
  - put_non_full_vcs[1] drops to 0 after the 3rd flit.
  - raising rready delivers rdata in order with correct rlast, and the credit returns.
- Inject a B flit (id=3, resp=0) and an R flit in the same cycle window:
  - bvalid and rvalid both assert.
  - a bogus tag=7 flit on vc0 is discarded.
  - RST_N low mid-WDATA returns the FSM to IDLE with all valids 0.

Source files
------------

// File: rtl/axi4_master_bridge.sv
// AXI4 master-side network endpoint.
// TX: AW/W/AR beats become one flit each (VC0 = writes, VC1 = reads).
// RX: per-VC receive queues feed the B and R channels.
module axi4_master_bridge #(
  parameter int FLIT_WIDTH = 69,
  parameter int NUM_VCS    = 2,
  parameter int SRC_ID     = 0,
  parameter int SLAVE_BASE = 2,
  parameter int ROUTE_BIT  = 31,
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RXQ_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  // AW
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  // W
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  // AR
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  // B
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  // R
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  // network
  output logic [FLIT_WIDTH-1:0] put_flit,
  output logic                  put_flit_valid,
  input  logic [NUM_VCS-1:0]    get_non_full_vcs,
  output logic                  get_non_full_vcs_ready,
  input  logic [FLIT_WIDTH-1:0] get_flit,
  output logic                  get_flit_ready,
  output logic [NUM_VCS-1:0]    put_non_full_vcs,
  output logic                  put_non_full_vcs_valid
);

  localparam logic [2:0] TAG_AW = 3'd0, TAG_W = 3'd1, TAG_B = 3'd2,
                         TAG_AR = 3'd3, TAG_R = 3'd4;
  localparam int REQ_PAD = 64 - 3 - 2 - ID_W - ADDR_W - 13;
  localparam int W_PAD   = 64 - 3 - DATA_W - DATA_W/8 - 1;
  localparam int PTR_W   = $clog2(RXQ_DEPTH);
  localparam int CNT_W   = $clog2(RXQ_DEPTH + 1);
  localparam int VC_BIT  = FLIT_WIDTH - 5;

  typedef enum logic {IDLE, WDATA} state_t;

  state_t     state, stateNxt;
  logic       prioWrite;   // 1: write wins the next AW/AR conflict
  logic [1:0] destQ;       // slave port of the burst in flight
  logic       grantW, grantR, wAcc;

  function automatic logic [1:0] routeDest(input logic [ADDR_W-1:0] a);
    return 2'(SLAVE_BASE) + {1'b0, a[ROUTE_BIT]};
  endfunction

  logic [63:0] awPayload, arPayload, wPayload;
  assign awPayload = {TAG_AW, 2'(SRC_ID), awid, awaddr, awlen, awsize, awburst, {REQ_PAD{1'b0}}};
  assign arPayload = {TAG_AR, 2'(SRC_ID), arid, araddr, arlen, arsize, arburst, {REQ_PAD{1'b0}}};
  assign wPayload  = {TAG_W, wdata, wstrb, wlast, {W_PAD{1'b0}}};

  // ---------------- TX FSM ----------------

  // state register
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= stateNxt;

  // next state: AW grant opens a burst, the wlast beat closes it
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:  if (grantW) stateNxt = WDATA;
      WDATA: if (wAcc && wlast) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // outputs: arbitration, handshakes and the outgoing flit
  always_comb begin
    logic wrCand, rdCand;
    wrCand   = awvalid && get_non_full_vcs[0];
    rdCand   = arvalid && get_non_full_vcs[1];
    grantW   = 1'b0;
    grantR   = 1'b0;
    wAcc     = 1'b0;
    put_flit = '0;
    if (state == IDLE) begin
      grantW = wrCand && (prioWrite || !rdCand);
      grantR = rdCand && !grantW;
    end else begin
      wAcc = wvalid && get_non_full_vcs[0];
    end
    if (grantW)      put_flit = {1'b1, 1'b0,  routeDest(awaddr), 1'b0, awPayload};
    else if (grantR) put_flit = {1'b1, 1'b1,  routeDest(araddr), 1'b1, arPayload};
    else if (wAcc)   put_flit = {1'b1, wlast, destQ,             1'b0, wPayload};
  end

  assign awready        = grantW;
  assign arready        = grantR;
  assign wready         = wAcc;
  assign put_flit_valid = grantW | grantR | wAcc;

  // priority pointer flips on every grant; burst destination latched on AW
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      prioWrite <= 1'b1;
      destQ     <= '0;
    end else begin
      if (grantW) begin
        prioWrite <= 1'b0;
        destQ     <= routeDest(awaddr);
      end else if (grantR) begin
        prioWrite <= 1'b1;
      end
    end

  // ---------------- RX queues ----------------

  logic [NUM_VCS-1:0][63:0] head;
  logic [NUM_VCS-1:0]       nonEmpty, popReq;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_rxq
    logic [63:0]      mem [RXQ_DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic [CNT_W-1:0] cnt;
    logic             push, full, doPush;

    assign push     = get_flit[FLIT_WIDTH-1] && (get_flit[VC_BIT] == 1'(v));
    assign full     = (cnt == CNT_W'(RXQ_DEPTH));
    assign doPush   = push && !full;
    assign head[v]  = mem[rp];
    assign nonEmpty[v] = (cnt != '0);
    // one spare slot absorbs the flit already in flight when credit drops
    assign put_non_full_vcs[v] = (cnt <= CNT_W'(RXQ_DEPTH - 2));

    // storage
    always_ff @(posedge CLK)
      if (doPush) mem[wp] <= get_flit[63:0];

    // pointers and occupancy
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (doPush)    wp <= (wp == PTR_W'(RXQ_DEPTH-1)) ? '0 : wp + PTR_W'(1);
        if (popReq[v]) rp <= (rp == PTR_W'(RXQ_DEPTH-1)) ? '0 : rp + PTR_W'(1);
        unique case ({doPush, popReq[v]})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: ;
        endcase
      end

    // a flit arriving with no room means the sender ignored credit
    always @(posedge CLK)
      if (RST_N) assert (!(push && full)) else $error("rx vc%0d overflow, flit dropped", v);
  end

  // head decode; stray tags are dropped as soon as they reach the head
  logic bHeadOk, rHeadOk;
  assign bHeadOk   = nonEmpty[0] && (head[0][63:61] == TAG_B);
  assign rHeadOk   = nonEmpty[1] && (head[1][63:61] == TAG_R);
  assign popReq[0] = nonEmpty[0] && (!bHeadOk || bready);
  assign popReq[1] = nonEmpty[1] && (!rHeadOk || rready);

  assign bvalid = bHeadOk;
  assign bid    = head[0][60 -: ID_W];
  assign bresp  = head[0][60-ID_W -: 2];
  assign rvalid = rHeadOk;
  assign rid    = head[1][60 -: ID_W];
  assign rdata  = head[1][60-ID_W -: DATA_W];
  assign rresp  = head[1][60-ID_W-DATA_W -: 2];
  assign rlast  = head[1][60-ID_W-DATA_W-2];

  assign get_non_full_vcs_ready = 1'b1;
  assign get_flit_ready         = 1'b1;
  assign put_non_full_vcs_valid = 1'b1;

  logic unusedBits;
  assign unusedBits = ^{get_flit[FLIT_WIDTH-2:FLIT_WIDTH-4], head};

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Directed bench for axi4_master_bridge.
module tb_axi4_master_bridge;

  logic        CLK, RST_N;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, arvalid, arready;
  logic [3:0]  wstrb;
  logic        bvalid, bready, rlast, rvalid, rready;
  logic [68:0] put_flit, get_flit;
  logic        put_flit_valid, get_non_full_vcs_ready, get_flit_ready, put_non_full_vcs_valid;
  logic [1:0]  get_non_full_vcs, put_non_full_vcs;

  int checks = 0;
  int failures = 0;

  axi4_master_bridge dut (
    .CLK(CLK), .RST_N(RST_N),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .put_flit(put_flit), .put_flit_valid(put_flit_valid),
    .get_non_full_vcs(get_non_full_vcs), .get_non_full_vcs_ready(get_non_full_vcs_ready),
    .get_flit(get_flit), .get_flit_ready(get_flit_ready),
    .put_non_full_vcs(put_non_full_vcs), .put_non_full_vcs_valid(put_non_full_vcs_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // inbound R flit on vc1, id 5, resp OKAY
  function automatic logic [68:0] rFlit(input logic [31:0] d, input logic last);
    return {1'b1, 1'b1, 2'd0, 1'b1, 3'd4, 4'd5, d, 2'd0, last, 22'd0};
  endfunction

  logic [31:0] rd [4];

  initial begin
    rd[0] = 32'hD000_0000; rd[1] = 32'hD111_1111; rd[2] = 32'hD222_2222; rd[3] = 32'hD333_3333;
    RST_N = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0;
    wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    get_flit = '0; get_non_full_vcs = 2'b11;

    // ---- reset state
    #12;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_put_flit_valid", put_flit_valid, 0);
    chk("rst_put_non_full", put_non_full_vcs, 2'b11);
    chk("rst_tied", {get_non_full_vcs_ready, get_flit_ready, put_non_full_vcs_valid}, 3'b111);
    tick(); RST_N = 1'b1;

    // ---- write burst, 2 beats
    tick(); awvalid = 1'b1; awaddr = 32'h0000_0010; awlen = 8'd1; awid = 4'd3;
    settle();
    chk("wr_awready", awready, 1);
    chk("wr_wready_c0", wready, 0);
    chk("wr_aw_flit", put_flit,
        {1'b1, 1'b0, 2'd2, 1'b0, 3'd0, 2'd0, 4'd3, 32'h0000_0010, 8'd1, 3'd2, 2'd1, 10'd0});
    tick(); awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h0000_00A1; wlast = 1'b0;
    settle();
    chk("wr_w0_ready", wready, 1);
    chk("wr_w0_flit", put_flit, {1'b1, 1'b0, 2'd2, 1'b0, 3'd1, 32'h0000_00A1, 4'hF, 1'b0, 24'd0});
    tick(); wdata = 32'h0000_00B2; wlast = 1'b1;
    settle();
    chk("wr_w1_ready", wready, 1);
    chk("wr_w1_flit", put_flit, {1'b1, 1'b1, 2'd2, 1'b0, 3'd1, 32'h0000_00B2, 4'hF, 1'b1, 24'd0});
    tick(); wvalid = 1'b0; wlast = 1'b0;
    settle();
    chk("wr_done_pfv", put_flit_valid, 0);

    // ---- single read to slave 1
    tick(); arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd5; arlen = 8'd0;
    settle();
    chk("rd_arready", arready, 1);
    chk("rd_ar_flit", put_flit,
        {1'b1, 1'b1, 2'd3, 1'b1, 3'd3, 2'd0, 4'd5, 32'h8000_0000, 8'd0, 3'd2, 2'd1, 10'd0});
    tick(); arvalid = 1'b0;
    settle();
    chk("rd_arready_1cyc", arready, 0);

    // ---- AW/AR conflicts: write first, then alternate
    tick(); awvalid = 1'b1; awaddr = 32'h0000_0020; awlen = 8'd0; awid = 4'd1;
    arvalid = 1'b1; araddr = 32'h0000_0004; arid = 4'd2;
    settle();
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    tick(); awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; wdata = 32'h0000_00C3;
    settle();
    chk("arb1_wdata_wready", wready, 1);
    chk("arb1_wdata_no_ar", arready, 0);
    tick(); wvalid = 1'b0; wlast = 1'b0; awvalid = 1'b1; awid = 4'd4;
    settle();
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    chk("arb2_ar_dest_vc", put_flit[66:64], {2'd2, 1'b1});
    tick();
    settle();
    chk("arb3_awready", awready, 1);
    chk("arb3_arready", arready, 0);
    tick(); awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1;
    settle();
    chk("arb3_wdata_no_ar", arready, 0);
    tick(); wvalid = 1'b0; wlast = 1'b0;
    settle();
    chk("arb4_arready", arready, 1);
    tick(); arvalid = 1'b0;

    // ---- VC0 blocked
    get_non_full_vcs = 2'b10; awvalid = 1'b1; awaddr = 32'h0000_0030; awlen = 8'd0;
    settle();
    chk("blk_awready", awready, 0);
    chk("blk_pfv", put_flit_valid, 0);
    tick();
    settle();
    chk("blk_pfv_2", put_flit_valid, 0);
    tick(); get_non_full_vcs = 2'b11;
    settle();
    chk("unblk_awready", awready, 1);
    chk("unblk_pfv", put_flit_valid, 1);
    chk("unblk_vc", put_flit[64], 0);
    tick(); awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; get_non_full_vcs = 2'b10;
    settle();
    chk("blk_wready", wready, 0);
    tick(); get_non_full_vcs = 2'b11;
    settle();
    chk("unblk_wready", wready, 1);
    tick(); wvalid = 1'b0; wlast = 1'b0;

    // ---- 4 R flits with rready low, then drain
    get_flit = rFlit(rd[0], 1'b0);
    tick(); get_flit = rFlit(rd[1], 1'b0);
    settle();
    chk("rx1_credit", put_non_full_vcs[1], 1);
    chk("rx1_rvalid", rvalid, 1);
    tick(); get_flit = rFlit(rd[2], 1'b0);
    settle();
    chk("rx2_credit", put_non_full_vcs[1], 1);
    tick(); get_flit = rFlit(rd[3], 1'b1);
    settle();
    chk("rx3_credit", put_non_full_vcs[1], 0);
    tick(); get_flit = '0;
    settle();
    chk("rx4_credit", put_non_full_vcs[1], 0);
    chk("rx4_vc0_credit", put_non_full_vcs[0], 1);
    for (int i = 0; i < 4; i++) begin
      tick(); rready = 1'b1;
      settle();
      chk("drain_rvalid", rvalid, 1);
      chk("drain_rdata", rdata, rd[i]);
      chk("drain_rlast", rlast, (i == 3));
      chk("drain_rid", rid, 4'd5);
      chk("drain_credit", put_non_full_vcs[1], (i >= 2));
    end
    tick();
    settle();
    chk("drain_empty", rvalid, 0);
    chk("drain_credit_back", put_non_full_vcs, 2'b11);
    rready = 1'b0;

    // ---- B and R together, then a bogus tag on vc0
    tick(); get_flit = {1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 4'd3, 2'd0, 55'd0};
    tick(); get_flit = rFlit(32'hCAFE_F00D, 1'b1);
    tick(); get_flit = {1'b1, 1'b1, 2'd0, 1'b0, 3'd7, 61'd0};
    settle();
    chk("br_bvalid", bvalid, 1);
    chk("br_bid", bid, 4'd3);
    chk("br_bresp", bresp, 2'd0);
    chk("br_rvalid", rvalid, 1);
    chk("br_rdata", rdata, 32'hCAFE_F00D);
    tick(); get_flit = '0; bready = 1'b1; rready = 1'b1;
    settle();
    chk("br_bvalid_hold", bvalid, 1);
    tick();
    settle();
    chk("bogus_no_bvalid", bvalid, 0);
    chk("bogus_no_rvalid", rvalid, 0);
    tick();
    settle();
    chk("bogus_dropped_credit", put_non_full_vcs, 2'b11);
    tick(); get_flit = {1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 4'd9, 2'd2, 55'd0};
    tick(); get_flit = '0;
    settle();
    chk("b2_bvalid", bvalid, 1);
    chk("b2_bid_bresp", {bid, bresp}, {4'd9, 2'd2});
    tick(); bready = 1'b0; rready = 1'b0;
    settle();
    chk("b2_popped", bvalid, 0);

    // ---- reset in the middle of a burst
    tick(); awvalid = 1'b1; awaddr = 32'h8000_0040; awlen = 8'd3;
    settle();
    chk("mid_awready", awready, 1);
    chk("mid_aw_dest", put_flit[66:65], 2'd3);
    tick(); awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0; wdata = 32'h0000_0055;
    get_flit = rFlit(32'h1234_5678, 1'b1);
    settle();
    chk("mid_w0_ready", wready, 1);
    chk("mid_w0_dest_tail", put_flit[67:65], {1'b0, 2'd3});
    tick(); get_flit = '0;
    settle();
    chk("mid_w1_ready", wready, 1);
    chk("mid_rvalid", rvalid, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_pfv", put_flit_valid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_credit", put_non_full_vcs, 2'b11);
    tick(); RST_N = 1'b1;
    settle();
    chk("post_rst_wready", wready, 0);
    chk("post_rst_pfv", put_flit_valid, 0);
    tick(); wvalid = 1'b0; awvalid = 1'b1; awlen = 8'd0; awaddr = 32'h0000_0000;
    settle();
    chk("post_rst_awready", awready, 1);
    chk("post_rst_aw_dest", put_flit[66:65], 2'd2);
    tick(); awvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
